// File: rtl/bus_xbar.sv
// N-host to M-device crossbar: fixed-priority arbitration, mask/base address decode,
// one transfer per cycle with the response routed back one cycle after the grant.
module bus_xbar #(
    parameter int NrDevices    = 4,
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,

    input  logic [NrHosts-1:0]                        host_req_i,
    output logic [NrHosts-1:0]                        host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
    input  logic [NrHosts-1:0]                        host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
    output logic [NrHosts-1:0]                        host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
    output logic [NrHosts-1:0]                        host_err_o,

    output logic [NrDevices-1:0]                      device_req_o,
    output logic [NrDevices-1:0][AddressWidth-1:0]    device_addr_o,
    output logic [NrDevices-1:0]                      device_we_o,
    output logic [NrDevices-1:0][DataWidth/8-1:0]     device_be_o,
    output logic [NrDevices-1:0][DataWidth-1:0]       device_wdata_o,
    input  logic [NrDevices-1:0]                      device_rvalid_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]       device_rdata_i,
    input  logic [NrDevices-1:0]                      device_err_i,

    input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_mask
);

    localparam int HostIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic                    any_req;
    logic [HostIdxW-1:0]     host_sel_d;
    logic                    dev_hit;
    logic [DevIdxW-1:0]      dev_sel_d;
    logic [AddressWidth-1:0] win_addr;
    logic                    win_we;
    logic [DataWidth/8-1:0]  win_be;
    logic [DataWidth-1:0]    win_wdata;

    logic                    pend_q;
    logic [HostIdxW-1:0]     host_sel_q;
    logic [DevIdxW-1:0]      dev_sel_q;
    logic                    derr_q;

    // Arbitration: scanning downwards leaves the lowest-indexed requester selected.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        any_req    = 1'b0;
        host_sel_d = '0;
        for (int h = NrHosts - 1; h >= 0; h--) begin
            if (host_req_i[h]) begin
                any_req    = 1'b1;
                host_sel_d = HostIdxW'(h);
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        if (any_req) begin
            win_addr  = host_addr_i[host_sel_d];
            win_we    = host_we_i[host_sel_d];
            win_be    = host_be_i[host_sel_d];
            win_wdata = host_wdata_i[host_sel_d];
        end
    end

    // Decode: overlapping regions resolve to the lowest device index.
    always_comb begin
        dev_hit   = 1'b0;
        dev_sel_d = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                dev_hit   = 1'b1;
                dev_sel_d = DevIdxW'(d);
            end
        end
    end

    always_comb begin
        host_gnt_o   = '0;
        device_req_o = '0;
        if (any_req) begin
            host_gnt_o[host_sel_d] = 1'b1;
            if (dev_hit) begin
                device_req_o[dev_sel_d] = 1'b1;
            end
        end
        for (int d = 0; d < NrDevices; d++) begin
            device_addr_o[d]  = win_addr;
            device_we_o[d]    = win_we;
            device_be_o[d]    = win_be;
            device_wdata_o[d] = win_wdata;
        end
    end

    // derr_q tracks pend_q so a stale decode error never produces a spurious response.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            pend_q     <= 1'b0;
            host_sel_q <= '0;
            dev_sel_q  <= '0;
            derr_q     <= 1'b0;
        end else begin
            pend_q <= any_req;
            derr_q <= any_req & ~dev_hit;
            if (any_req) begin
                host_sel_q <= host_sel_d;
                dev_sel_q  <= dev_sel_d;
            end
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (derr_q) begin
            host_rvalid_o[host_sel_q] = 1'b1;
            host_err_o[host_sel_q]    = 1'b1;
        end else begin
            host_rvalid_o[host_sel_q] = pend_q & device_rvalid_i[dev_sel_q];
            host_err_o[host_sel_q]    = pend_q & device_err_i[dev_sel_q];
        end
        for (int h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = derr_q ? '0 : device_rdata_i[dev_sel_q];
        end
    end

endmodule

// File: tb/tb_bus_xbar.sv
// Directed bench for bus_xbar: inputs change 1 ns after the rising edge, outputs are
// checked on the falling edge against hand-computed values.
module tb_bus_xbar;

    localparam int NrDevices = 4;
    localparam int NrHosts   = 2;
    localparam int DW        = 32;
    localparam int AW        = 32;

    logic                           clk_i = 1'b0;
    logic                           rst_i;
    logic [NrHosts-1:0]             host_req_i;
    logic [NrHosts-1:0]             host_gnt_o;
    logic [NrHosts-1:0][AW-1:0]     host_addr_i;
    logic [NrHosts-1:0]             host_we_i;
    logic [NrHosts-1:0][DW/8-1:0]   host_be_i;
    logic [NrHosts-1:0][DW-1:0]     host_wdata_i;
    logic [NrHosts-1:0]             host_rvalid_o;
    logic [NrHosts-1:0][DW-1:0]     host_rdata_o;
    logic [NrHosts-1:0]             host_err_o;
    logic [NrDevices-1:0]           device_req_o;
    logic [NrDevices-1:0][AW-1:0]   device_addr_o;
    logic [NrDevices-1:0]           device_we_o;
    logic [NrDevices-1:0][DW/8-1:0] device_be_o;
    logic [NrDevices-1:0][DW-1:0]   device_wdata_o;
    logic [NrDevices-1:0]           device_rvalid_i;
    logic [NrDevices-1:0][DW-1:0]   device_rdata_i;
    logic [NrDevices-1:0]           device_err_i;
    logic [NrDevices-1:0][AW-1:0]   cfg_device_addr_base;
    logic [NrDevices-1:0][AW-1:0]   cfg_device_addr_mask;

    int total = 0;
    int bad   = 0;

    bus_xbar #(
        .NrDevices(NrDevices), .NrHosts(NrHosts), .DataWidth(DW), .AddressWidth(AW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
        .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
        .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
        .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
        .device_err_i(device_err_i),
        .cfg_device_addr_base(cfg_device_addr_base), .cfg_device_addr_mask(cfg_device_addr_mask)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        host_req_i      = '0;
        host_addr_i     = '0;
        host_we_i       = '0;
        host_be_i       = '0;
        host_wdata_i    = '0;
        device_rvalid_i = '0;
        device_rdata_i  = '0;
        device_err_i    = '0;
    endtask

    task automatic host_drive(input int h, input logic [AW-1:0] addr, input logic we,
                              input logic [DW-1:0] wdata);
        host_req_i[h]   = 1'b1;
        host_addr_i[h]  = addr;
        host_we_i[h]    = we;
        host_be_i[h]    = 4'hF;
        host_wdata_i[h] = wdata;
    endtask

    task automatic dev_respond(input int d, input logic [DW-1:0] rdata, input logic err);
        device_rvalid_i[d] = 1'b1;
        device_rdata_i[d]  = rdata;
        device_err_i[d]    = err;
    endtask

    initial begin
        cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = ~32'h000F_FFFF;
        cfg_device_addr_base[1] = 32'h0002_0000; cfg_device_addr_mask[1] = ~32'h0000_03FF;
        cfg_device_addr_base[2] = 32'h0003_0000; cfg_device_addr_mask[2] = ~32'h0000_03FF;
        cfg_device_addr_base[3] = 32'h0004_0000; cfg_device_addr_mask[3] = ~32'h0000_FFFF;
        idle_inputs();
        rst_i = 1'b1;

        // Reset state
        next_cycle();
        next_cycle();
        settle();
        check("rst_rvalid", 64'(host_rvalid_o), 64'h0);
        check("rst_err",    64'(host_err_o),    64'h0);
        next_cycle();
        rst_i = 1'b0;

        // Host0 read of device 0
        host_drive(0, 32'h0010_0010, 1'b0, '0);
        settle();
        check("rd0_gnt",   64'(host_gnt_o),       64'b01);
        check("rd0_dreq",  64'(device_req_o),     64'b0001);
        check("rd0_addr0", 64'(device_addr_o[0]), 64'h0010_0010);
        check("rd0_addr3", 64'(device_addr_o[3]), 64'h0010_0010);
        next_cycle();
        idle_inputs();
        dev_respond(0, 32'hDEAD_BEEF, 1'b0);
        settle();
        check("rd0_rvalid", 64'(host_rvalid_o),   64'b01);
        check("rd0_rdata0", 64'(host_rdata_o[0]), 64'hDEAD_BEEF);
        check("rd0_rdata1", 64'(host_rdata_o[1]), 64'hDEAD_BEEF);
        check("rd0_err",    64'(host_err_o),      64'b00);

        // Contention: both hosts write, host0 wins first
        next_cycle();
        idle_inputs();
        host_drive(0, 32'h0002_0000, 1'b1, 32'h1111_0000);
        host_drive(1, 32'h0003_0004, 1'b1, 32'h2222_0004);
        settle();
        check("wr_gnt_a",  64'(host_gnt_o),        64'b01);
        check("wr_dreq_a", 64'(device_req_o),      64'b0010);
        check("wr_we_a",   64'(device_we_o),       64'b1111);
        check("wr_wd_a",   64'(device_wdata_o[1]), 64'h1111_0000);
        next_cycle();
        host_req_i[0] = 1'b0;
        dev_respond(1, 32'h0, 1'b0);
        settle();
        check("wr_gnt_b",    64'(host_gnt_o),        64'b10);
        check("wr_dreq_b",   64'(device_req_o),      64'b0100);
        check("wr_addr_b",   64'(device_addr_o[2]),  64'h0003_0004);
        check("wr_wd_b",     64'(device_wdata_o[2]), 64'h2222_0004);
        check("wr_rvalid_a", 64'(host_rvalid_o),     64'b01);
        next_cycle();
        idle_inputs();
        dev_respond(2, 32'h0, 1'b0);
        settle();
        check("wr_rvalid_b", 64'(host_rvalid_o),    64'b10);
        check("idle_gnt",    64'(host_gnt_o),       64'b00);
        check("idle_dreq",   64'(device_req_o),     64'b0000);
        check("idle_addr",   64'(device_addr_o[0]), 64'h0);
        check("idle_we",     64'(device_we_o),      64'b0000);

        // Host1 read of device 3, device reports an error
        next_cycle();
        idle_inputs();
        host_drive(1, 32'h0004_0800, 1'b0, '0);
        settle();
        check("d3_gnt",  64'(host_gnt_o),   64'b10);
        check("d3_dreq", 64'(device_req_o), 64'b1000);
        next_cycle();
        idle_inputs();
        dev_respond(3, 32'h1234_5678, 1'b1);
        settle();
        check("d3_rvalid", 64'(host_rvalid_o),   64'b10);
        check("d3_err",    64'(host_err_o),      64'b10);
        check("d3_rdata",  64'(host_rdata_o[1]), 64'h1234_5678);

        // Unmapped address: decode error
        next_cycle();
        idle_inputs();
        host_drive(0, 32'h9000_0000, 1'b0, '0);
        settle();
        check("derr_gnt",  64'(host_gnt_o),   64'b01);
        check("derr_dreq", 64'(device_req_o), 64'b0000);
        next_cycle();
        idle_inputs();
        device_rdata_i[0] = 32'hCAFE_F00D;
        settle();
        check("derr_rvalid", 64'(host_rvalid_o),   64'b01);
        check("derr_err",    64'(host_err_o),      64'b01);
        check("derr_rdata",  64'(host_rdata_o[0]), 64'h0);
        next_cycle();
        settle();
        check("derr_clear", 64'(host_rvalid_o), 64'b00);

        // Back-to-back reads by host0
        next_cycle();
        idle_inputs();
        host_drive(0, 32'h0010_0000, 1'b0, '0);
        settle();
        check("b2b_gnt1", 64'(host_gnt_o),   64'b01);
        check("b2b_dreq1", 64'(device_req_o), 64'b0001);
        next_cycle();
        host_addr_i[0] = 32'h0010_0004;
        dev_respond(0, 32'h0000_00A0, 1'b0);
        settle();
        check("b2b_gnt2",   64'(host_gnt_o),       64'b01);
        check("b2b_addr2",  64'(device_addr_o[0]), 64'h0010_0004);
        check("b2b_rv1",    64'(host_rvalid_o),    64'b01);
        check("b2b_rdata1", 64'(host_rdata_o[0]),  64'hA0);
        next_cycle();
        host_req_i = '0;
        dev_respond(0, 32'h0000_00A1, 1'b0);
        settle();
        check("b2b_rv2",    64'(host_rvalid_o),   64'b01);
        check("b2b_rdata2", 64'(host_rdata_o[0]), 64'hA1);

        // Reset right after a normal grant drops the response
        next_cycle();
        idle_inputs();
        host_drive(1, 32'h0010_0000, 1'b0, '0);
        next_cycle();
        idle_inputs();
        rst_i = 1'b1;
        next_cycle();
        dev_respond(0, 32'h5555_5555, 1'b1);
        settle();
        check("rstp_rvalid", 64'(host_rvalid_o), 64'b00);
        check("rstp_err",    64'(host_err_o),    64'b00);

        // Reset right after a decode-error grant drops the error response
        next_cycle();
        idle_inputs();
        rst_i = 1'b0;
        host_drive(0, 32'h9000_0000, 1'b0, '0);
        next_cycle();
        idle_inputs();
        rst_i = 1'b1;
        next_cycle();
        settle();
        check("rste_rvalid", 64'(host_rvalid_o), 64'b00);
        check("rste_err",    64'(host_err_o),    64'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
